// File: rtl/huff_pkg.sv
// Shared constants, default Huffman table and FSM state type for the symbol
// encoder and for any bench that needs the golden code table.
package huff_pkg;
  localparam int SYM_W   = 4;
  localparam int CODE_W  = 9;
  localparam int LEN_W   = 4;
  localparam int NUM_SYM = 10;

  localparam logic [CODE_W-1:0] DEF_CODE [NUM_SYM] = '{
    9'b000000000, 9'b000000001, 9'b000000100, 9'b000000101, 9'b000001100,
    9'b000001101, 9'b000011100, 9'b000011101, 9'b000011110, 9'b000011111
  };
  localparam logic [LEN_W-1:0] DEF_LEN [NUM_SYM] = '{
    4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5
  };

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

  function automatic logic tbl_write_ok(input logic [SYM_W-1:0] addr,
                                        input logic [LEN_W-1:0] len);
    return (addr < SYM_W'(NUM_SYM)) && (len != '0) && (len <= LEN_W'(CODE_W));
  endfunction
endpackage

// File: rtl/huff_sym_fifo.sv
// Synchronous FIFO with combinational head read, so the table lookup can
// happen in the same cycle the head is popped.
module huff_sym_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rptr];
  // A pop frees the slot the simultaneous push lands in.
  assign w_push  = i_push & (~o_full | i_pop);
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/huff_sym_encoder.sv
// Buffers 4-bit symbols, looks up their Huffman code in a writable table and
// holds code/length stable with trans_start high for len cycles per symbol.
module huff_sym_encoder
  import huff_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sym_valid,
  output logic              o_sym_ready,
  input  logic [SYM_W-1:0]  i_sym,
  input  logic              i_sym_last,
  input  logic              i_tbl_we,
  input  logic [SYM_W-1:0]  i_tbl_addr,
  input  logic [CODE_W-1:0] i_tbl_code,
  input  logic [LEN_W-1:0]  i_tbl_len,
  output logic [CODE_W-1:0] o_data,
  output logic [LEN_W-1:0]  o_data_len,
  output logic              o_trans_start,
  output logic              o_busy,
  output logic              o_err
);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic              w_full;
  logic              w_empty;
  logic [SYM_W:0]    w_head;
  logic              w_sym_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_chain;
  logic              w_tbl_wr;
  logic [CODE_W-1:0] w_code_arr [NUM_SYM];
  logic [LEN_W-1:0]  w_len_arr  [NUM_SYM];
  logic [CODE_W-1:0] w_lk_code;
  logic [LEN_W-1:0]  w_lk_len;

  state_t            r_state;
  logic [CODE_W-1:0] r_data;
  logic [LEN_W-1:0]  r_len;
  logic              r_last;
  logic [LEN_W-1:0]  r_cnt;
  logic [GW-1:0]     r_gcnt;
  logic              r_trans;
  logic              r_err;

  assign o_sym_ready = ~w_full;
  assign w_sym_ok    = (i_sym <= SYM_W'(NUM_SYM - 1));
  // Illegal symbols complete the handshake but never enter the buffer.
  assign w_push      = i_sym_valid & o_sym_ready & w_sym_ok;
  assign w_tbl_wr    = i_tbl_we & tbl_write_ok(i_tbl_addr, i_tbl_len);

  huff_sym_fifo #(.W(SYM_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata ({i_sym_last, i_sym}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  for (genvar gi = 0; gi < NUM_SYM; gi++) begin : g_tbl
    logic [CODE_W-1:0] r_code;
    logic [LEN_W-1:0]  r_elen;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_code <= DEF_CODE[gi];
        r_elen <= DEF_LEN[gi];
      end else if (w_tbl_wr && (i_tbl_addr == SYM_W'(gi))) begin
        r_code <= i_tbl_code;
        r_elen <= i_tbl_len;
      end
    end
    assign w_code_arr[gi] = r_code;
    assign w_len_arr[gi]  = r_elen;
  end

  // Lookup reads the registered table, so a same-cycle write is not seen.
  assign w_lk_code = w_code_arr[w_head[SYM_W-1:0]];
  assign w_lk_len  = w_len_arr[w_head[SYM_W-1:0]];
  assign w_chain   = ~r_last & ~w_empty;
  assign w_pop     = ((r_state == S_IDLE) & ~w_empty) |
                     ((r_state == S_EMIT) & (r_cnt == '0) & w_chain);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_len   <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_trans <= 1'b0;
    end else begin
      if (w_pop) begin
        r_data <= w_lk_code;
        r_len  <= w_lk_len;
        r_last <= w_head[SYM_W];
        r_cnt  <= w_lk_len - LEN_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_EMIT;
            r_trans <= 1'b1;
          end
        end
        S_EMIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - LEN_W'(1);
          end else if (!w_chain) begin
            r_state <= S_GAP;
            r_trans <= 1'b0;
            r_gcnt  <= GW'(GAP_CYC - 1);
          end
        end
        S_GAP: begin
          if (r_gcnt == '0) r_state <= S_IDLE;
          else              r_gcnt  <= r_gcnt - GW'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_trans <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_err <= 1'b0;
    else       r_err <= (i_sym_valid & o_sym_ready & ~w_sym_ok) |
                        (i_tbl_we & ~tbl_write_ok(i_tbl_addr, i_tbl_len));
  end

  assign o_data        = r_data;
  assign o_data_len    = r_len;
  assign o_trans_start = r_trans;
  assign o_busy        = (r_state != S_IDLE) | ~w_empty;
  assign o_err         = r_err;
endmodule

// File: tb/tb_huff_sym_encoder.sv
// Directed bench for huff_sym_encoder: a queue of expected codes plus a
// serializer-level bit stream model, checked every cycle trans_start is high.
module tb_huff_sym_encoder;
  logic       i_clk;
  logic       i_rst;
  logic       i_sym_valid;
  logic       o_sym_ready;
  logic [3:0] i_sym;
  logic       i_sym_last;
  logic       i_tbl_we;
  logic [3:0] i_tbl_addr;
  logic [8:0] i_tbl_code;
  logic [3:0] i_tbl_len;
  logic [8:0] o_data;
  logic [3:0] o_data_len;
  logic       o_trans_start;
  logic       o_busy;
  logic       o_err;

  huff_sym_encoder #(.FIFO_DEPTH(4), .GAP_CYC(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sym_valid(i_sym_valid), .o_sym_ready(o_sym_ready),
    .i_sym(i_sym), .i_sym_last(i_sym_last), .i_tbl_we(i_tbl_we), .i_tbl_addr(i_tbl_addr),
    .i_tbl_code(i_tbl_code), .i_tbl_len(i_tbl_len), .o_data(o_data), .o_data_len(o_data_len),
    .o_trans_start(o_trans_start), .o_busy(o_busy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [8:0] code;
    logic [3:0] len;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  m_code [10];
  logic [3:0]  m_len  [10];
  int          checks = 0;
  int          errors = 0;
  int          err_hits = 0;
  int          exp_err = 0;
  int          trans_hi = 0;
  int          run_cur = 0;
  int          last_run = 0;
  int          stream_n = 0;
  logic [63:0] stream = '0;
  logic        ready_low_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic reset_model();
    m_code = '{9'b0, 9'b1, 9'b100, 9'b101, 9'b1100, 9'b1101,
               9'b11100, 9'b11101, 9'b11110, 9'b11111};
    m_len  = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5};
  endtask

  task automatic push(input logic [3:0] s, input logic l);
    int n = 0;
    i_sym_valid = 1'b1;
    i_sym       = s;
    i_sym_last  = l;
    while (!o_sym_ready && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("push_ready", o_sym_ready, 1);
    if (s <= 4'd9) exp_q.push_back('{code: m_code[s], len: m_len[s]});
    else           exp_err++;
    $display("push sym=%0d last=%0d", s, l);
    @(posedge i_clk); #1;
    i_sym_valid = 1'b0;
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [8:0] c, input logic [3:0] l);
    i_tbl_we   = 1'b1;
    i_tbl_addr = a;
    i_tbl_code = c;
    i_tbl_len  = l;
    if (a <= 4'd9 && l >= 4'd1 && l <= 4'd9) begin
      m_code[a] = c;
      m_len[a]  = l;
    end else begin
      exp_err++;
    end
    $display("tbl_write addr=%0d code=%b len=%0d", a, c, l);
    @(posedge i_clk); #1;
    i_tbl_we = 1'b0;
  endtask

  task automatic wait_trans();
    int n = 0;
    @(negedge i_clk);
    while (!o_trans_start && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    chk("wait_trans", o_trans_start, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while (o_busy && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    chk("wait_idle", o_busy, 0);
    @(posedge i_clk); #1;
  endtask

  // Per-cycle compare against the expected-code queue and bit-stream model.
  int   rem = 0;
  exp_t cur;
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_err) err_hits++;
      if (!o_sym_ready) ready_low_seen = 1'b1;
      if (i_rst) begin
        rem = 0;
        run_cur = 0;
        continue;
      end
      if (o_trans_start) begin
        run_cur++;
        trans_hi++;
      end else if (run_cur != 0) begin
        last_run = run_cur;
        run_cur = 0;
      end
      if (o_trans_start) begin
        if (rem == 0) begin
          if (exp_q.size() == 0) chk("trans_unexpected", o_trans_start, 0);
          else begin
            cur = exp_q.pop_front();
            rem = int'(cur.len);
          end
        end
        if (rem != 0) begin
          chk("data", o_data, cur.code);
          chk("data_len", o_data_len, cur.len);
          stream = {stream[62:0], o_data[rem-1]};
          stream_n++;
          rem--;
        end
      end else if (rem != 0) begin
        chk("burst_short", o_trans_start, 1);
        rem = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_sym_valid = 1'b0; i_sym = '0; i_sym_last = 1'b0;
    i_tbl_we = 1'b0; i_tbl_addr = '0; i_tbl_code = '0; i_tbl_len = '0;
    reset_model();
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_trans", o_trans_start, 0);
    chk("rst_data", o_data, 0);
    chk("rst_len", o_data_len, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ready", o_sym_ready, 1);
    @(posedge i_clk); #1;

    // Single symbol: latency 2, two-cycle burst, gap, then idle.
    push(4'd0, 1'b1);
    @(negedge i_clk); chk("t1_lat_n1", o_trans_start, 0);
    @(negedge i_clk); chk("t1_lat_n2", o_trans_start, 1);
    chk("t1_data", o_data, 9'b000000000);
    chk("t1_len", o_data_len, 2);
    @(negedge i_clk); chk("t1_hi2", o_trans_start, 1);
    @(negedge i_clk); chk("t1_gap1", o_trans_start, 0);
    chk("t1_busy_gap", o_busy, 1);
    @(negedge i_clk); chk("t1_gap2", o_trans_start, 0);
    wait_idle();
    chk("t1_run", last_run, 2);
    $display("t1 done run=%0d", last_run);

    // Back-to-back frame 2,9,4.
    stream_n = 0;
    push(4'd2, 1'b0);
    push(4'd9, 1'b0);
    push(4'd4, 1'b1);
    wait_idle();
    chk("t2_run", last_run, 12);
    chk("t2_bits", stream_n, 12);
    chk("t2_stream", stream[11:0], 12'b100111111100);
    $display("t2 done stream=%b", stream[11:0]);

    // Six len-5 symbols into a depth-4 buffer.
    ready_low_seen = 1'b0;
    stream_n = 0;
    push(4'd6, 1'b0); push(4'd7, 1'b0); push(4'd8, 1'b0);
    push(4'd9, 1'b0); push(4'd6, 1'b0); push(4'd7, 1'b1);
    wait_idle();
    chk("t3_run", last_run, 30);
    chk("t3_ready_low", ready_low_seen, 1);
    chk("t3_bits", stream_n, 30);
    chk("t3_q_empty", exp_q.size(), 0);
    $display("t3 done run=%0d", last_run);

    // Illegal symbol and illegal table writes.
    begin
      int e0, h0;
      e0 = err_hits;
      h0 = trans_hi;
      push(4'd12, 1'b1);
      repeat (6) @(negedge i_clk);
      chk("t4_err_sym", err_hits, e0 + 1);
      chk("t4_no_trans", trans_hi, h0);
      @(posedge i_clk); #1;
      tbl_write(4'd3, 9'h1ff, 4'd0);
      repeat (3) @(negedge i_clk);
      chk("t4_err_len0", err_hits, e0 + 2);
      @(posedge i_clk); #1;
      tbl_write(4'd10, 9'h1, 4'd2);
      repeat (3) @(negedge i_clk);
      chk("t4_err_addr", err_hits, e0 + 3);
      @(posedge i_clk); #1;
      push(4'd3, 1'b1);
      wait_trans();
      chk("t4_code3", o_data, 9'b000000101);
      chk("t4_len3", o_data_len, 3);
      wait_idle();
      $display("t4 done err_hits=%0d", err_hits);
    end

    // Same-cycle write/lookup emits old code; next lookup sees new one.
    push(4'd1, 1'b1);
    tbl_write(4'd1, 9'b101101101, 4'd9);
    wait_trans();
    chk("t5_old_code", o_data, 9'b000000001);
    chk("t5_old_len", o_data_len, 2);
    wait_idle();
    chk("t5_old_run", last_run, 2);
    push(4'd1, 1'b1);
    wait_trans();
    chk("t5_new_code", o_data, 9'b101101101);
    chk("t5_new_len", o_data_len, 9);
    wait_idle();
    chk("t5_new_run", last_run, 9);
    $display("t5 done run=%0d", last_run);

    // Reset in the middle of a burst.
    push(4'd8, 1'b1);
    wait_trans();
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    exp_q.delete();
    reset_model();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("t6_trans", o_trans_start, 0);
    chk("t6_data", o_data, 0);
    chk("t6_len", o_data_len, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_ready", o_sym_ready, 1);
    @(posedge i_clk); #1;
    push(4'd1, 1'b1);
    wait_trans();
    chk("t6_tbl_default", o_data, 9'b000000001);
    chk("t6_len_default", o_data_len, 2);
    wait_idle();
    $display("t6 done");

    chk("end_q_empty", exp_q.size(), 0);
    chk("end_err_count", err_hits, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
